// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared MEM-stage definitions: states, control bit indices, bubble constants
package pipe_defs;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Bit positions inside MEM_ctrl
  localparam int MEMREAD   = 1;
  localparam int MEMWRITE  = 0;

  localparam int WB_CTRL_W = 4;

  // Values loaded into MEM/WB while an access is outstanding
  localparam logic [31:0]          BUBBLE_INSTR = 32'h0;
  localparam logic [WB_CTRL_W-1:0] BUBBLE_WB    = '0;
  localparam logic [4:0]           BUBBLE_RD    = 5'h0;

  function automatic logic is_mem_op(input logic [1:0] mem_ctrl);
    return mem_ctrl[MEMREAD] | mem_ctrl[MEMWRITE];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - WAIT-cycle counter with expiry compare (built only with MEM_TIMEOUT_EN)
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  assign expired = (cnt == TMO_W'(TIMEOUT_CYCLES));

  // Count unanswered WAIT cycles; saturate at the limit so expiry holds until the FSM leaves WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data-memory handshake, pipeline stall, registered MEM/WB payload (option: MEM_TIMEOUT_EN)
module mem_access_unit
  import pipe_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instr_i,
  input  logic [1:0]           MEM_ctrl_i,
  input  logic [WB_CTRL_W-1:0] WB_ctrl_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          rt_data_i,
  input  logic [4:0]           rd_index_i,
  input  logic [31:0]          pc_add4_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [31:0]          dmem_addr_o,
  output logic [31:0]          dmem_wdata_o,
  input  logic [31:0]          dmem_rdata_i,
  input  logic                 dmem_ready_i,
  output logic                 stall_o,
  output logic [31:0]          instr_o,
  output logic [WB_CTRL_W-1:0] WB_ctrl_o,
  output logic [31:0]          alu_result_o,
  output logic [4:0]           rd_index_o,
  output logic [31:0]          pc_add4_o,
  output logic [31:0]          mem_data_o,
  output logic                 mem_fault_o
);

  // The counter must be able to represent the limit it compares against
  if ((2 ** TMO_W) <= TIMEOUT_CYCLES) begin : g_bad_tmo_cfg
    $error("mem_access_unit: TMO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        op;
  logic        we_in;
  logic        expired;
  logic        take_payload;
  logic [31:0] mem_data_nx;
  logic        fault_nx;

  assign op    = is_mem_op(MEM_ctrl_i);
  assign we_in = MEM_ctrl_i[MEMWRITE];   // write wins when both bits are set

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state == IDLE),
    .inc     ((state == WAIT) && !dmem_ready_i),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Memory bus: live inputs on the issue cycle, latched copy while waiting; never request in reset
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = we_in;
    dmem_addr_o  = alu_result_i;
    dmem_wdata_o = rt_data_i;
    if (state == WAIT) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = we_q;
      dmem_addr_o  = addr_q;
      dmem_wdata_o = wdata_q;
    end else begin
      dmem_req_o   = op;
    end
    if (rst_i) begin
      dmem_req_o = 1'b0;
    end
  end

  // Decide whether this edge loads the real payload or a bubble, and what data/fault go with it
  always_comb begin
    take_payload = 1'b0;
    mem_data_nx  = 32'h0;
    fault_nx     = 1'b0;
    if (state == IDLE) begin
      take_payload = !op || dmem_ready_i;
    end else begin
      take_payload = dmem_ready_i || expired;
      fault_nx     = !dmem_ready_i && expired;
    end
    if (dmem_req_o && dmem_ready_i && !dmem_we_o) begin
      mem_data_nx = dmem_rdata_i;
    end
    stall_o = dmem_req_o && !dmem_ready_i && !expired;
  end

  // FSM with registered MEM/WB outputs and the request latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      instr_o      <= 32'h0;
      WB_ctrl_o    <= '0;
      alu_result_o <= 32'h0;
      rd_index_o   <= 5'h0;
      pc_add4_o    <= 32'h0;
      mem_data_o   <= 32'h0;
      mem_fault_o  <= 1'b0;
    end else begin
      alu_result_o <= alu_result_i;
      pc_add4_o    <= pc_add4_i;
      if (take_payload) begin
        state       <= IDLE;
        instr_o     <= instr_i;
        WB_ctrl_o   <= WB_ctrl_i;
        rd_index_o  <= rd_index_i;
        mem_data_o  <= mem_data_nx;
        mem_fault_o <= fault_nx;
      end else begin
        state       <= WAIT;
        instr_o     <= BUBBLE_INSTR;
        WB_ctrl_o   <= BUBBLE_WB;
        rd_index_o  <= BUBBLE_RD;
        mem_data_o  <= 32'h0;
        mem_fault_o <= 1'b0;
      end
      if (state == IDLE && op && !dmem_ready_i) begin
        addr_q  <= alu_result_i;
        wdata_q <= rt_data_i;
        we_q    <= we_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i, alu_result_i, rt_data_i, pc_add4_i, dmem_rdata_i;
  logic [1:0]  MEM_ctrl_i;
  logic [3:0]  WB_ctrl_i;
  logic [4:0]  rd_index_i;
  logic        dmem_ready_i;
  logic        dmem_req_o, dmem_we_o, stall_o, mem_fault_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, instr_o, alu_result_o, pc_add4_o, mem_data_o;
  logic [3:0]  WB_ctrl_o;
  logic [4:0]  rd_index_o;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .MEM_ctrl_i   (MEM_ctrl_i),
    .WB_ctrl_i    (WB_ctrl_i),
    .alu_result_i (alu_result_i),
    .rt_data_i    (rt_data_i),
    .rd_index_i   (rd_index_i),
    .pc_add4_i    (pc_add4_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ready_i (dmem_ready_i),
    .stall_o      (stall_o),
    .instr_o      (instr_o),
    .WB_ctrl_o    (WB_ctrl_o),
    .alu_result_o (alu_result_o),
    .rd_index_o   (rd_index_o),
    .pc_add4_o    (pc_add4_o),
    .mem_data_o   (mem_data_o),
    .mem_fault_o  (mem_fault_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [1:0] K_PAY = 2'd0, K_BUB = 2'd1, K_ZERO = 2'd2;

  typedef struct {
    logic        rst;
    logic [1:0]  mc;
    logic [31:0] alu, wdata;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] rdata;
    logic        x_req, x_we, x_stall;
    logic [31:0] x_addr, x_wdata;
    logic [1:0]  kind;
    logic [31:0] x_mem;
    logic        x_fault;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] instr, alu, pc, mem;
    logic [3:0]  wb;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic [1:0] mc, input logic [31:0] alu,
                              input logic [31:0] wdata, input logic [4:0] rd, input logic ready,
                              input logic [31:0] rdata, input logic x_req, input logic x_we,
                              input logic x_stall, input logic [31:0] x_addr, input logic [31:0] x_wdata,
                              input logic [1:0] kind, input logic [31:0] x_mem, input logic x_fault);
    vec_t v;
    v.rst = rst; v.mc = mc; v.alu = alu; v.wdata = wdata; v.rd = rd; v.ready = ready;
    v.rdata = rdata; v.x_req = x_req; v.x_we = x_we; v.x_stall = x_stall; v.x_addr = x_addr;
    v.x_wdata = x_wdata; v.kind = kind; v.x_mem = x_mem; v.x_fault = x_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // One clock: drive at negedge, check bus/stall mid-cycle, compare MEM/WB after the edge
  task automatic run(input vec_t v);
    exp_t e, g;
    @(negedge clk_i);
    rst_i        = v.rst;
    MEM_ctrl_i   = v.mc;
    alu_result_i = v.alu;
    rt_data_i    = v.wdata;
    rd_index_i   = v.rd;
    instr_i      = 32'h1000_0000 | 32'(v.rd);
    WB_ctrl_i    = 4'b1010;
    pc_add4_i    = 32'h400 + 32'(v.rd);
    dmem_ready_i = v.ready;
    dmem_rdata_i = v.rdata;
    #1;
    chk("req", 32'(dmem_req_o), 32'(v.x_req));
    if (!v.rst) chk("stall", 32'(stall_o), 32'(v.x_stall));
    if (v.x_req) begin
      chk("we", 32'(dmem_we_o), 32'(v.x_we));
      chk("addr", dmem_addr_o, v.x_addr);
      if (v.x_we) chk("wdata", dmem_wdata_o, v.x_wdata);
    end
    e.kind  = v.kind;
    e.instr = (v.kind == K_PAY) ? instr_i : 32'h0;
    e.wb    = (v.kind == K_PAY) ? WB_ctrl_i : 4'h0;
    e.rd    = (v.kind == K_PAY) ? v.rd : 5'h0;
    e.alu   = (v.kind == K_ZERO) ? 32'h0 : v.alu;
    e.pc    = (v.kind == K_ZERO) ? 32'h0 : pc_add4_i;
    e.mem   = (v.kind == K_PAY) ? v.x_mem : 32'h0;
    e.fault = (v.kind == K_PAY) ? v.x_fault : 1'b0;
    scb.push_back(e);
    @(posedge clk_i);
    #1;
    if (scb.size() == 0) begin
      chk("scb_empty", 32'h1, 32'h0);
    end else begin
      g = scb.pop_front();
      chk("instr_o", instr_o, g.instr);
      chk("WB_ctrl_o", 32'(WB_ctrl_o), 32'(g.wb));
      chk("rd_index_o", 32'(rd_index_o), 32'(g.rd));
      chk("mem_data_o", mem_data_o, g.mem);
      chk("mem_fault_o", 32'(mem_fault_o), 32'(g.fault));
      if (g.kind != K_BUB) begin
        chk("alu_result_o", alu_result_o, g.alu);
        chk("pc_add4_o", pc_add4_o, g.pc);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    //            rst mc     alu           wdata         rd  rdy rdata         req we stl addr          wdata         kind   mem           flt
    tbl[0] = mk(1'b0, 2'b00, 32'h1234,     32'h0,        5,  0, 32'h0,        0, 0, 0, 32'h1234,     32'h0,        K_PAY, 32'h0,        0);
    tbl[1] = mk(1'b0, 2'b10, 32'h40,       32'h0,        6,  1, 32'hCAFEF00D, 1, 0, 0, 32'h40,       32'h0,        K_PAY, 32'hCAFEF00D, 0);
    tbl[2] = mk(1'b0, 2'b01, 32'h44,       32'h11223344, 7,  1, 32'hDEAD0000, 1, 1, 0, 32'h44,       32'h11223344, K_PAY, 32'h0,        0);
    tbl[3] = mk(1'b0, 2'b11, 32'h48,       32'h55667788, 8,  1, 32'hBEEF0000, 1, 1, 0, 32'h48,       32'h55667788, K_PAY, 32'h0,        0);
    tbl[4] = mk(1'b0, 2'b00, 32'h9999,     32'h0,        9,  1, 32'h77777777, 0, 0, 0, 32'h9999,     32'h0,        K_PAY, 32'h0,        0);
    tbl[5] = mk(1'b0, 2'b10, 32'h4C,       32'h0,        10, 1, 32'h0BADCAFE, 1, 0, 0, 32'h4C,       32'h0,        K_PAY, 32'h0BADCAFE, 0);

    // Reset: request gated off even with a load presented, all outputs cleared
    run(mk(1'b1, 2'b10, 32'hAAAA, 32'hBBBB, 3, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, K_ZERO, 32'h0, 0));

    // Single-cycle cases from IDLE
    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Store with 3 stall cycles; inputs scrambled while waiting to prove the latch holds the bus
    run(mk(1'b0, 2'b01, 32'h80,       32'hA5A5A5A5, 12, 0, 32'h0, 1, 1, 1, 32'h80, 32'hA5A5A5A5, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b00, 32'hFFFF0000, 32'h12121212, 12, 0, 32'h0, 1, 1, 1, 32'h80, 32'hA5A5A5A5, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b10, 32'hFFFF0004, 32'h34343434, 12, 0, 32'h0, 1, 1, 1, 32'h80, 32'hA5A5A5A5, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b01, 32'h80,       32'hA5A5A5A5, 12, 1, 32'h99999999, 1, 1, 0, 32'h80, 32'hA5A5A5A5, K_PAY, 32'h0, 0));

    // Back-to-back: a waited load right after, completing with data
    run(mk(1'b0, 2'b10, 32'h90, 32'h0, 13, 0, 32'h0,        1, 0, 1, 32'h90, 32'h0, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b10, 32'h90, 32'h0, 13, 1, 32'h13572468, 1, 0, 0, 32'h90, 32'h0, K_PAY, 32'h13572468, 0));

    // Reset during WAIT abandons the request; next load completes zero-wait from IDLE
    run(mk(1'b0, 2'b10, 32'h100, 32'h0, 14, 0, 32'h0,        1, 0, 1, 32'h100, 32'h0, K_BUB,  32'h0, 0));
    run(mk(1'b0, 2'b10, 32'h100, 32'h0, 14, 0, 32'h0,        1, 0, 1, 32'h100, 32'h0, K_BUB,  32'h0, 0));
    run(mk(1'b1, 2'b10, 32'h100, 32'h0, 14, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0, K_ZERO, 32'h0, 0));
    run(mk(1'b0, 2'b10, 32'h200, 32'h0, 15, 1, 32'h600DF00D, 1, 0, 0, 32'h200, 32'h0, K_PAY,  32'h600DF00D, 0));

    // A long wait with no response
`ifdef MEM_TIMEOUT_EN
    run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 0, 32'h0, 1, 0, 1, 32'h300, 32'h0, K_BUB, 32'h0, 0));
    for (int i = 0; i < TMO; i++)
      run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 0, 32'h0, 1, 0, 1, 32'h300, 32'h0, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 0, 32'hFEEDFEED, 1, 0, 0, 32'h300, 32'h0, K_PAY, 32'h0, 1));
    run(mk(1'b0, 2'b00, 32'h304, 32'h0, 17, 0, 32'h0, 0, 0, 0, 32'h304, 32'h0, K_PAY, 32'h0, 0));
`else
    run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 0, 32'h0, 1, 0, 1, 32'h300, 32'h0, K_BUB, 32'h0, 0));
    for (int i = 0; i < 20; i++)
      run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 0, 32'h0, 1, 0, 1, 32'h300, 32'h0, K_BUB, 32'h0, 0));
    run(mk(1'b0, 2'b10, 32'h300, 32'h0, 16, 1, 32'h2468ACE0, 1, 0, 0, 32'h300, 32'h0, K_PAY, 32'h2468ACE0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
